// File: rtl/frame_fill_pkg.sv
// frame_fill_pkg: state and pattern-mode types shared by the frame fill engine and its pattern generator
package frame_fill_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} fill_state_t;
  typedef enum logic [1:0] {SOLID, CHECKER, HGRAD, VGRAD} fill_mode_t;
endpackage

// File: rtl/frame_fill_pattern.sv
// frame_fill_pattern: combinational pixel generator for solid, checker, horizontal and vertical gradient fills
module frame_fill_pattern
  import frame_fill_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int CHK_SHIFT = 3,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  fill_mode_t       mode,
  input  logic [PIX_W-1:0] fill_color,
  output logic [PIX_W-1:0] pixel
);
  logic [X_W-1:0] xs;
  logic [Y_W-1:0] ys;
  always_comb begin
    xs = x >> CHK_SHIFT;
    ys = y >> CHK_SHIFT;
    pixel = mode == SOLID   ? fill_color :
            mode == CHECKER ? ((xs[0] ^ ys[0]) ? ~fill_color : fill_color) :
            mode == HGRAD   ? PIX_W'(x) : PIX_W'(y);
  end
endmodule

// File: rtl/frame_fill_engine.sv
// frame_fill_engine: walks an H_RES x V_RES frame in raster order, writing one pattern pixel per accepted beat.
// Optional abort input enabled by defining FRAME_FILL_ABORT_EN.
module frame_fill_engine
  import frame_fill_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int PIX_W     = 8,
  parameter int CHK_SHIFT = 3,
  localparam int ADDR_W    = $clog2(H_RES * V_RES),
  localparam int X_W       = $clog2(H_RES),
  localparam int Y_W       = $clog2(V_RES),
  localparam int LAST_ADDR = H_RES * V_RES - 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
`ifdef FRAME_FILL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  input  logic              wr_ready
);
  fill_state_t      state;
  fill_mode_t       mode_q, mode_sel;
  logic [PIX_W-1:0] color_q, color_sel, pix;
  logic [X_W-1:0]   x, nx;
  logic [Y_W-1:0]   y, ny;
  logic             x_end, last, abort_hit;
`ifdef FRAME_FILL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif
  // In IDLE the pattern sees the live inputs so the first pixel is ready on the start edge
  always_comb begin
    x_end     = x == X_W'(H_RES - 1);
    last      = wr_addr == ADDR_W'(LAST_ADDR);
    nx        = (state == WRITE && !x_end) ? x + 1'b1 : '0;
    ny        = state != WRITE ? '0 : x_end ? y + 1'b1 : y;
    mode_sel  = state == IDLE ? fill_mode_t'(mode) : mode_q;
    color_sel = state == IDLE ? fill_color : color_q;
  end
  frame_fill_pattern #(
    .PIX_W(PIX_W), .CHK_SHIFT(CHK_SHIFT), .X_W(X_W), .Y_W(Y_W)
  ) u_pattern (
    .x(nx), .y(ny), .mode(mode_sel), .fill_color(color_sel), .pixel(pix)
  );
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      mode_q  <= SOLID;
      color_q <= '0;
      x       <= '0;
      y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= WRITE;
          mode_q  <= mode_sel;
          color_q <= fill_color;
          x       <= '0;
          y       <= '0;
          busy    <= 1'b1;
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= pix;
        end
        WRITE: if (abort_hit || (wr_ready && last)) begin
          state   <= abort_hit ? IDLE : DONE;
          done    <= !abort_hit;
          x       <= '0;
          y       <= '0;
          busy    <= 1'b0;
          wr_en   <= 1'b0;
          wr_addr <= '0;
        end else if (wr_ready) begin
          x       <= nx;
          y       <= ny;
          wr_addr <= wr_addr + 1'b1;
          wr_data <= pix;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_fill_engine.sv
// tb_frame_fill_engine: directed fills checked against a pixel scoreboard; abort steps need FRAME_FILL_ABORT_EN
module tb_frame_fill_engine;
  localparam int H = 260, V = 3, PW = 8, CS = 2, N = H * V, AW = $clog2(N);
  logic Clk = 0, Reset_n = 0, start = 0, wr_ready = 0;
  logic [1:0] mode = 0;
  logic [PW-1:0] fill_color = 0;
  logic busy, done, wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
`ifdef FRAME_FILL_ABORT_EN
  logic abort = 0;
`endif
  typedef struct {logic [AW-1:0] a; logic [PW-1:0] d;} wr_t;
  wr_t exp_q[$];
  int tests = 0, fails = 0, dones = 0, exp_dones = 0, rdy_mode = 0, cyc = 0;
  logic hold_v = 0;
  logic [AW-1:0] hold_a;
  logic [PW-1:0] hold_d;

  always #5 Clk = ~Clk;

  frame_fill_engine #(.H_RES(H), .V_RES(V), .PIX_W(PW), .CHK_SHIFT(CS)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
`ifdef FRAME_FILL_ABORT_EN
    .abort(abort),
`endif
    .start(start), .mode(mode), .fill_color(fill_color), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  function automatic logic [PW-1:0] model(logic [1:0] m, logic [PW-1:0] c, int x, int y);
    case (m)
      2'd0: return c;
      2'd1: return (((x >> CS) ^ (y >> CS)) & 1) != 0 ? ~c : c;
      2'd2: return PW'(x);
      default: return PW'(y);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted write must match the head of the expected queue
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (done) dones++;
      if (hold_v && wr_en) begin
        chk("hold_addr", 32'(wr_addr), 32'(hold_a));
        chk("hold_data", 32'(wr_data), 32'(hold_d));
      end
      if (wr_en && wr_ready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL extra_write: observed addr %0h expected no write", wr_addr);
        end
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      hold_v = wr_en && !wr_ready;
      hold_a = wr_addr;
      hold_d = wr_data;
    end else hold_v = 0;
  end

  task automatic step();
    @(posedge Clk);
    #1;
    wr_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~wr_ready :
               rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic push_fill(logic [1:0] m, logic [PW-1:0] c);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        wr_t e;
        e.a = AW'(y * H + x);
        e.d = model(m, c, x, y);
        exp_q.push_back(e);
      end
  endtask

  task automatic start_fill(logic [1:0] m, logic [PW-1:0] c);
    push_fill(m, c);
    mode = m;
    fill_color = c;
    start = 1;
    step();
    start = 0;
    mode = ~m;
    fill_color = ~c;
    chk("start_busy", 32'(busy), 1);
    chk("start_wr_en", 32'(wr_en), 1);
    chk("start_addr", 32'(wr_addr), 0);
  endtask

  task automatic wait_done(int bound, output int c);
    c = 0;
    while (!done && c < bound) begin
      step();
      c++;
    end
    chk("done_seen", 32'(done), 1);
    exp_dones++;
  endtask

  task automatic wait_addr(logic [AW-1:0] a);
    int c = 0;
    while (wr_addr != a && c < 50) begin
      step();
      c++;
    end
    chk("reach_addr", 32'(wr_addr), 32'(a));
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    Reset_n = 1;
    rdy_mode = 0;
    wr_ready = 1;
    step();
    // Solid fill at full rate: exact latency and one-cycle done
    start_fill(2'd0, 8'hA5);
    wait_done(N + 10, cyc);
    chk("done_latency", 32'(cyc), 32'(N));
    chk("done_busy", 32'(busy), 0);
    chk("done_wr_en", 32'(wr_en), 0);
    step();
    chk("done_pulse", 32'(done), 0);
    chk("queue_empty_solid", 32'(exp_q.size()), 0);
    // Checker with alternating backpressure
    rdy_mode = 1;
    start_fill(2'd1, 8'h0F);
    wait_done(3 * N, cyc);
    step();
    chk("queue_empty_checker", 32'(exp_q.size()), 0);
    // Gradients with random backpressure (HGRAD wraps at x=256)
    rdy_mode = 2;
    start_fill(2'd2, 8'h3C);
    wait_done(8 * N, cyc);
    step();
    chk("queue_empty_hgrad", 32'(exp_q.size()), 0);
    start_fill(2'd3, 8'hC3);
    wait_done(8 * N, cyc);
    step();
    chk("queue_empty_vgrad", 32'(exp_q.size()), 0);
    // start held high through WRITE and DONE: the next IDLE cycle restarts
    rdy_mode = 0;
    push_fill(2'd2, 8'h77);
    mode = 2'd2;
    fill_color = 8'h77;
    start = 1;
    step();
    wait_done(N + 10, cyc);
    chk("b2b_first_latency", 32'(cyc), 32'(N));
    push_fill(2'd2, 8'h77);
    step();
    chk("b2b_idle_busy", 32'(busy), 0);
    step();
    start = 0;
    chk("b2b_restart_busy", 32'(busy), 1);
    chk("b2b_restart_addr", 32'(wr_addr), 0);
    wait_done(N + 10, cyc);
    step();
    chk("queue_empty_b2b", 32'(exp_q.size()), 0);
    // Reset mid-fill at the fifth write: abandon frame, no done
    start_fill(2'd0, 8'h11);
    wait_addr(AW'(4));
    Reset_n = 0;
    rdy_mode = 3;
    wr_ready = 0;
    step();
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_addr", 32'(wr_addr), 0);
    Reset_n = 1;
    exp_q.delete();
    repeat (3) step();
    chk("midrst_no_done", 32'(done), 0);
    rdy_mode = 0;
    wr_ready = 1;
    start_fill(2'd1, 8'h5A);
    wait_done(N + 10, cyc);
    step();
    chk("queue_empty_after_rst", 32'(exp_q.size()), 0);
`ifdef FRAME_FILL_ABORT_EN
    start_fill(2'd0, 8'h66);
    wait_addr(AW'(6));
    rdy_mode = 3;
    wr_ready = 0;
    abort = 1;
    step();
    abort = 0;
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_addr", 32'(wr_addr), 0);
    exp_q.delete();
    step();
    chk("abort_no_done", 32'(done), 0);
    rdy_mode = 0;
    wr_ready = 1;
    start_fill(2'd3, 8'h99);
    wait_done(N + 10, cyc);
    step();
    chk("queue_empty_after_abort", 32'(exp_q.size()), 0);
`endif
    repeat (2) step();
    chk("done_count", 32'(dones), 32'(exp_dones));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
